aes_decrypt_iter: RTL



---
 rtl/aes_dec_pkg.sv | 112 +++++++++++
 rtl/aes_key_expand_step.sv | 19 +
 rtl/aes_decrypt_iter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/aes_dec_pkg.sv
// Shared AES-128 tables, FSM state type and round helpers for the decrypt engine.
// The optional key cache is selected in the top by the AES_DEC_KEY_CACHE_EN macro.
package aes_dec_pkg;

    typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL} fsm_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Byte k of the block sits at bits 127-8k; byte index = 4*column + row.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = INV_SBOX[s[8*k +: 8]];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    // temp = SubWord(RotWord(w3)) ^ Rcon; each new word chains off the previous one.
    function automatic logic [127:0] key_expand_step(input logic [127:0] rk, input logic [7:0] rcon);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {SBOX[rk[23:16]], SBOX[rk[15:8]], SBOX[rk[7:0]], SBOX[rk[31:24]]} ^ {rcon, 24'h000000};
        n0 = rk[127:96] ^ t;
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// Combinational AES-128 key schedule step: rk_next = KeyExpand(rk_prev, Rcon[round]).
// Shared by the encrypt and decrypt paths; round indices outside 1..10 use Rcon 0.
module aes_key_expand_step
    import aes_dec_pkg::*;
(
    input  logic [127:0] rk_prev,
    input  logic [3:0]   round,
    output logic [127:0] rk_next
);

    logic [7:0] rcon;

    always_comb begin
        rcon = 8'h00;
        if (round >= 4'd1 && round <= 4'd10) rcon = RCON[round];
        rk_next = key_expand_step(rk_prev, rcon);
    end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: key expansion, then one inverse round per clock.
// Optional AES_DEC_KEY_CACHE_EN skips key expansion when the same key is reused.
module aes_decrypt_iter
    import aes_dec_pkg::*;
#(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             ready,
    input  logic [KEY_W-1:0] cipher_text_128,
    input  logic [KEY_W-1:0] key_128,
    output logic [KEY_W-1:0] plain_text_128,
    output logic             valid_out
);

    if (NR != 10 || KEY_W != 128) begin : g_bad_cfg
        $error("aes_decrypt_iter supports only NR=10 and KEY_W=128");
    end

    fsm_state_t       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [KEY_W-1:0] ct_q, ct_d;
    logic [KEY_W-1:0] data_q, data_d;
    logic [KEY_W-1:0] pt_q, pt_d;
    logic [KEY_W-1:0] rk_q [0:NR];
    logic [KEY_W-1:0] rk_d [0:NR];
    logic [KEY_W-1:0] rk_prev, rk_next;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
`ifdef AES_DEC_KEY_CACHE_EN
    logic             key_cached_q, key_cached_d;
`endif

    assign rk_prev = rk_q[cnt_q - 4'd1];

    aes_key_expand_step u_key_step (
        .rk_prev (rk_prev),
        .round   (cnt_q),
        .rk_next (rk_next)
    );

    // Handshake: a request is taken on a rising edge where valid_in=1 and
    // ready=1; ready is low for the whole block, so no request is ever queued.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ct_d    = ct_q;
        data_d  = data_q;
        pt_d    = pt_q;
        rk_d    = rk_q;
        ready_d = ready_q;
        valid_d = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
        key_cached_d = key_cached_q;
`endif
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (valid_in && ready_q) begin
                    ct_d    = cipher_text_128;
                    rk_d[0] = key_128;
                    ready_d = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
                    if (key_cached_q && key_128 == rk_q[0]) begin
                        state_d = INIT;
                    end else begin
                        state_d      = KEXP;
                        cnt_d        = 4'd1;
                        key_cached_d = 1'b0;
                    end
`else
                    state_d = KEXP;
                    cnt_d   = 4'd1;
`endif
                end
            end
            KEXP: begin
                rk_d[cnt_q] = rk_next;
                if (cnt_q == 4'(NR)) begin
                    state_d = INIT;
`ifdef AES_DEC_KEY_CACHE_EN
                    key_cached_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            INIT: begin
                data_d  = ct_q ^ rk_q[NR];
                cnt_d   = 4'(NR - 1);
                state_d = ROUND;
            end
            ROUND: begin
                data_d = inv_mix_columns(inv_sub_bytes(inv_shift_rows(data_q)) ^ rk_q[cnt_q]);
                if (cnt_q == 4'd1) state_d = FINAL;
                else               cnt_d   = cnt_q - 4'd1;
            end
            FINAL: begin
                pt_d    = inv_sub_bytes(inv_shift_rows(data_q)) ^ rk_q[0];
                valid_d = 1'b1;
                ready_d = 1'b1;
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ct_q    <= '0;
            data_q  <= '0;
            pt_q    <= '0;
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            key_cached_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ct_q    <= ct_d;
            data_q  <= data_d;
            pt_q    <= pt_d;
            rk_q    <= rk_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
`ifdef AES_DEC_KEY_CACHE_EN
            key_cached_q <= key_cached_d;
`endif
        end
    end

    assign ready          = ready_q;
    assign valid_out      = valid_q;
    assign plain_text_128 = pt_q;

endmodule
